// File: rtl/fruit_draw_if.sv
// Control/status bundle between the fruit frame sequencer and its datapath/VGA side.
interface fruit_draw_if;
  logic        go;
  logic        frame_tick;
  logic        pause;
  logic        ld_background;
  logic        ld_xy;
  logic        new_fruit;
  logic [3:0]  counter4bit;
  logic [6:0]  counter7bit;
  logic [15:0] bg_counter;
  logic        plot;
  logic        busy;
  logic        frame_done;

  modport master (
    input  go, frame_tick, pause,
    output ld_background, ld_xy, new_fruit, counter4bit, counter7bit,
           bg_counter, plot, busy, frame_done
  );

  modport slave (
    output go, frame_tick, pause,
    input  ld_background, ld_xy, new_fruit, counter4bit, counter7bit,
           bg_counter, plot, busy, frame_done
  );
endinterface

// File: rtl/fruit_draw_control.sv
// Frame sequencer: background sweep, 4x4 fruit sprite, then wait for a frame tick and step the fall.
// Optional macro FRUIT_PAUSE_EN: a tick with pause=1 redraws the frame without stepping the fall.
module fruit_draw_control #(
  parameter int X_MAX      = 159,
  parameter int Y_MAX      = 119,
  parameter int FALL_STEP  = 1,
  parameter int FALL_MAX   = 100,
  parameter int PLOT_DELAY = 2
) (
  input  logic          clock,
  input  logic          resetn,
  fruit_draw_if.master  bus
);

  localparam logic [7:0] X_LAST = 8'(X_MAX);
  localparam logic [6:0] Y_LAST = 7'(Y_MAX);
  localparam logic [7:0] F_LAST = 8'(FALL_MAX);

  typedef enum logic [2:0] {S_IDLE, S_BG, S_FRUIT, S_WAIT, S_STEP} state_t;

  state_t                state, state_nx;
  logic [7:0]            x_q, x_nx;
  logic [6:0]            y_q, y_nx;
  logic [3:0]            idx_q, idx_nx;
  logic [6:0]            fall_q, fall_nx;
  logic                  spawn_q, spawn_nx;
  logic                  ld_bg_q, ld_bg_nx;
  logic                  ld_xy_q, ld_xy_nx;
  logic                  new_fruit_q, new_fruit_nx;
  logic                  busy_q, busy_nx;
  logic                  done_q, done_nx;
  logic [PLOT_DELAY-1:0] plot_pipe;
  logic [7:0]            fall_sum;

  // Sum is one bit wider than the offset so the wrap test cannot overflow.
  function automatic logic [7:0] fall_add(input logic [6:0] cur);
    return {1'b0, cur} + 8'(FALL_STEP);
  endfunction

  assign fall_sum = fall_add(fall_q);

`ifndef FRUIT_PAUSE_EN
  logic unused_pause;
  assign unused_pause = bus.pause;
`endif

  always_comb begin
    state_nx     = state;
    x_nx         = x_q;
    y_nx         = y_q;
    idx_nx       = idx_q;
    fall_nx      = fall_q;
    spawn_nx     = spawn_q;
    ld_bg_nx     = 1'b0;
    ld_xy_nx     = 1'b0;
    new_fruit_nx = 1'b0;
    done_nx      = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.go) begin
          state_nx = S_BG;
          x_nx     = '0;
          y_nx     = '0;
          ld_bg_nx = 1'b1;
        end
      end
      S_BG: begin
        if (x_q == X_LAST) begin
          if (y_q == Y_LAST) begin
            // Last pixel stays on bg_counter while the sprite is drawn.
            state_nx     = S_FRUIT;
            idx_nx       = '0;
            ld_xy_nx     = 1'b1;
            new_fruit_nx = spawn_q;
          end else begin
            x_nx     = '0;
            y_nx     = y_q + 7'd1;
            ld_bg_nx = 1'b1;
          end
        end else begin
          x_nx     = x_q + 8'd1;
          ld_bg_nx = 1'b1;
        end
      end
      S_FRUIT: begin
        if (idx_q == 4'd15) begin
          state_nx = S_WAIT;
          idx_nx   = '0;
          done_nx  = 1'b1;
          spawn_nx = 1'b0;
        end else begin
          idx_nx       = idx_q + 4'd1;
          ld_xy_nx     = 1'b1;
          new_fruit_nx = spawn_q;
        end
      end
      S_WAIT: begin
        if (!bus.go) begin
          state_nx = S_IDLE;
        end else if (bus.frame_tick) begin
`ifdef FRUIT_PAUSE_EN
          if (bus.pause) begin
            state_nx = S_BG;
            x_nx     = '0;
            y_nx     = '0;
            ld_bg_nx = 1'b1;
          end else begin
            state_nx = S_STEP;
          end
`else
          state_nx = S_STEP;
`endif
        end
      end
      S_STEP: begin
        if (fall_sum > F_LAST) begin
          fall_nx  = '0;
          spawn_nx = 1'b1;
        end else begin
          fall_nx = fall_sum[6:0];
        end
        state_nx = S_BG;
        x_nx     = '0;
        y_nx     = '0;
        ld_bg_nx = 1'b1;
      end
      default: state_nx = S_IDLE;
    endcase
    busy_nx = (state_nx == S_BG) || (state_nx == S_FRUIT);
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state       <= S_IDLE;
      x_q         <= '0;
      y_q         <= '0;
      idx_q       <= '0;
      fall_q      <= '0;
      spawn_q     <= 1'b1;
      ld_bg_q     <= 1'b0;
      ld_xy_q     <= 1'b0;
      new_fruit_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      plot_pipe   <= '0;
    end else begin
      state       <= state_nx;
      x_q         <= x_nx;
      y_q         <= y_nx;
      idx_q       <= idx_nx;
      fall_q      <= fall_nx;
      spawn_q     <= spawn_nx;
      ld_bg_q     <= ld_bg_nx;
      ld_xy_q     <= ld_xy_nx;
      new_fruit_q <= new_fruit_nx;
      busy_q      <= busy_nx;
      done_q      <= done_nx;
      // Plot delay line runs in every state so trailing strobes drain after the frame.
      plot_pipe   <= (plot_pipe << 1) | PLOT_DELAY'(ld_bg_q | ld_xy_q);
    end
  end

  assign bus.ld_background = ld_bg_q;
  assign bus.ld_xy         = ld_xy_q;
  assign bus.new_fruit     = new_fruit_q;
  assign bus.counter4bit   = idx_q;
  assign bus.counter7bit   = fall_q;
  assign bus.bg_counter    = {1'b0, y_q, x_q};
  assign bus.plot          = plot_pipe[PLOT_DELAY-1];
  assign bus.busy          = busy_q;
  assign bus.frame_done    = done_q;

endmodule

// File: tb/tb_fruit_draw_control.sv
// Bench for fruit_draw_control: full-size instance for reset and one real frame,
// reduced-raster instance for the fall/wrap/tick/pause/go sequencing.
module tb_fruit_draw_control;
  localparam int SX = 7;
  localparam int SY = 3;
  localparam int PD = 2;

  typedef struct packed {
    logic        bg;
    logic        xy;
    logic [15:0] addr;
    logic        nf;
    logic [6:0]  c7;
  } pix_t;

  logic clock;
  logic resetn;

  fruit_draw_if bus_full();
  fruit_draw_if bus_small();

  fruit_draw_control u_full (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus_full.master)
  );

  fruit_draw_control #(.X_MAX(SX), .Y_MAX(SY)) u_small (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus_small.master)
  );

  pix_t        sb[$];
  int          vectors;
  int          miscompares;
  bit          use_small;
  bit          sb_en;
  int          n_ld;
  int          n_plot;
  int          n_fd;
  logic [PD-1:0] hist;
  pix_t        obs;
  logic        m_plot;
  logic        m_fd;
  logic [6:0]  cexp;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always_comb begin
    obs    = '0;
    m_plot = 1'b0;
    m_fd   = 1'b0;
    if (use_small) begin
      obs.bg   = bus_small.ld_background;
      obs.xy   = bus_small.ld_xy;
      obs.addr = bus_small.ld_xy ? {12'd0, bus_small.counter4bit} : bus_small.bg_counter;
      obs.nf   = bus_small.new_fruit;
      obs.c7   = bus_small.counter7bit;
      m_plot   = bus_small.plot;
      m_fd     = bus_small.frame_done;
    end else begin
      obs.bg   = bus_full.ld_background;
      obs.xy   = bus_full.ld_xy;
      obs.addr = bus_full.ld_xy ? {12'd0, bus_full.counter4bit} : bus_full.bg_counter;
      obs.nf   = bus_full.new_fruit;
      obs.c7   = bus_full.counter7bit;
      m_plot   = bus_full.plot;
      m_fd     = bus_full.frame_done;
    end
  end

  // Monitor: pixel stream against the scoreboard, plot against the ld history.
  always @(negedge clock) begin
    pix_t exp_p;
    if (!resetn) begin
      hist = '0;
    end else begin
      vectors++;
      if (m_plot !== hist[PD-1]) begin
        miscompares++;
        $display("FAIL plot_delay t=%0t plot=%b required %b", $time, m_plot, hist[PD-1]);
      end
      if (m_plot) n_plot++;
      if (m_fd) n_fd++;
      if (sb_en && (obs.bg || obs.xy)) begin
        n_ld++;
        vectors++;
        if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL pixel_unexpected t=%0t got %h required none", $time, obs);
        end else begin
          exp_p = sb.pop_front();
          if (obs !== exp_p) begin
            miscompares++;
            $display("FAIL pixel t=%0t got bg=%b xy=%b addr=%h nf=%b c7=%0d required bg=%b xy=%b addr=%h nf=%b c7=%0d",
                     $time, obs.bg, obs.xy, obs.addr, obs.nf, obs.c7,
                     exp_p.bg, exp_p.xy, exp_p.addr, exp_p.nf, exp_p.c7);
          end
        end
      end
      hist = {hist[PD-2:0], obs.bg | obs.xy};
    end
  end

  function automatic logic [32:0] full_outs();
    return {bus_full.ld_background, bus_full.ld_xy, bus_full.new_fruit, bus_full.counter4bit,
            bus_full.counter7bit, bus_full.bg_counter, bus_full.plot, bus_full.busy,
            bus_full.frame_done};
  endfunction

  task automatic push_frame(input int xm, input int ym, input logic nf, input logic [6:0] c7);
    pix_t p;
    for (int y = 0; y <= ym; y++) begin
      for (int x = 0; x <= xm; x++) begin
        p.bg = 1'b1; p.xy = 1'b0; p.addr = {1'b0, 7'(y), 8'(x)}; p.nf = 1'b0; p.c7 = c7;
        sb.push_back(p);
      end
    end
    for (int i = 0; i < 16; i++) begin
      p.bg = 1'b0; p.xy = 1'b1; p.addr = {12'd0, 4'(i)}; p.nf = nf; p.c7 = c7;
      sb.push_back(p);
    end
  endtask

  task automatic wait_done(input string name, input int limit);
    int k;
    k = 0;
    while (!m_fd && k < limit) begin
      @(negedge clock);
      k++;
    end
    vectors++;
    if (m_fd !== 1'b1) begin
      miscompares++;
      $display("FAIL %s frame_done=%b after %0d cycles required 1", name, m_fd, limit);
    end
  endtask

  task automatic pulse_tick();
    bus_small.frame_tick = 1'b1;
    @(negedge clock);
    bus_small.frame_tick = 1'b0;
  endtask

  task automatic check_c7(input string name, input logic [6:0] want);
    vectors++;
    if (bus_small.counter7bit !== want) begin
      miscompares++;
      $display("FAIL %s counter7bit=%0d required %0d", name, bus_small.counter7bit, want);
    end
  endtask

  task automatic check_sb_empty(input string name);
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL %s pending_pixels=%0d required 0", name, sb.size());
    end
  endtask

  task automatic test_reset();
    int k;
    use_small = 1'b0;
    sb_en     = 1'b0;
    repeat (2) @(negedge clock);
    vectors++;
    if (full_outs() !== 33'd0) begin
      miscompares++;
      $display("FAIL reset_state outs=%h required 0", full_outs());
    end
    resetn = 1'b1;
    @(negedge clock);
    bus_full.go = 1'b1;
    k = 0;
    while (bus_full.bg_counter !== 16'h0A32 && k < 3000) begin
      @(negedge clock);
      k++;
    end
    vectors++;
    if (bus_full.bg_counter !== 16'h0A32 || bus_full.ld_background !== 1'b1) begin
      miscompares++;
      $display("FAIL reach_0a32 bg_counter=%h ld=%b required 0a32 1", bus_full.bg_counter,
               bus_full.ld_background);
    end
    resetn      = 1'b0;
    bus_full.go = 1'b0;
    @(posedge clock);
    #1;
    vectors++;
    if (full_outs() !== 33'd0) begin
      miscompares++;
      $display("FAIL reset_mid_bg outs=%h required 0", full_outs());
    end
    @(negedge clock);
    resetn = 1'b1;
    repeat (4) @(negedge clock);
    vectors++;
    if (full_outs() !== 33'd0) begin
      miscompares++;
      $display("FAIL idle_after_reset outs=%h required 0", full_outs());
    end
  endtask

  task automatic test_full_frame();
    use_small = 1'b0;
    sb.delete();
    n_ld = 0; n_plot = 0; n_fd = 0;
    sb_en = 1'b1;
    push_frame(159, 119, 1'b1, 7'd0);
    bus_full.go = 1'b1;
    wait_done("full_frame", 20000);
    vectors++;
    if (bus_full.bg_counter !== 16'h779F || bus_full.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL full_last_addr bg_counter=%h busy=%b required 779f 0", bus_full.bg_counter,
               bus_full.busy);
    end
    bus_full.go = 1'b0;
    repeat (PD + 3) @(negedge clock);
    check_sb_empty("full_sb");
    vectors++;
    if (n_ld != 19216 || n_plot != 19216 || n_fd != 1) begin
      miscompares++;
      $display("FAIL full_counts ld=%0d plot=%0d done=%0d required 19216 19216 1", n_ld, n_plot, n_fd);
    end
    sb_en = 1'b0;
  endtask

  task automatic test_first_and_step();
    use_small = 1'b1;
    sb.delete();
    sb_en = 1'b1;
    push_frame(SX, SY, 1'b1, 7'd0);
    bus_small.go = 1'b1;
    wait_done("small_first", 200);
    check_c7("small_first", 7'd0);
    push_frame(SX, SY, 1'b0, 7'd1);
    pulse_tick();
    wait_done("step", 200);
    check_c7("step", 7'd1);
    check_sb_empty("step_sb");
  endtask

  task automatic test_wrap();
    for (int k = 2; k <= 100; k++) begin
      push_frame(SX, SY, 1'b0, 7'(k));
      pulse_tick();
      wait_done("fall_run", 200);
    end
    check_c7("at_max", 7'd100);
    push_frame(SX, SY, 1'b1, 7'd0);
    pulse_tick();
    wait_done("wrap", 200);
    check_c7("wrap", 7'd0);
    push_frame(SX, SY, 1'b0, 7'd1);
    pulse_tick();
    wait_done("after_wrap", 200);
    check_c7("after_wrap", 7'd1);
    check_sb_empty("wrap_sb");
  endtask

  task automatic test_tick_dropped();
    push_frame(SX, SY, 1'b0, 7'd2);
    pulse_tick();
    repeat (10) @(negedge clock);
    pulse_tick();
    wait_done("tick_in_bg", 200);
    check_c7("tick_in_bg", 7'd2);
    repeat (10) @(negedge clock);
    check_sb_empty("tick_in_bg_sb");
    vectors++;
    if (bus_small.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL tick_dropped_busy busy=%b required 0", bus_small.busy);
    end
    cexp = 7'd2;
  endtask

  task automatic test_pause();
    bus_small.pause = 1'b1;
    for (int i = 0; i < 3; i++) begin
`ifdef FRUIT_PAUSE_EN
      push_frame(SX, SY, 1'b0, cexp);
`else
      push_frame(SX, SY, 1'b0, cexp + 7'(i + 1));
`endif
      pulse_tick();
      wait_done("pause_frame", 200);
    end
    bus_small.pause = 1'b0;
`ifndef FRUIT_PAUSE_EN
    cexp = cexp + 7'd3;
`endif
    check_c7("pause", cexp);
    check_sb_empty("pause_sb");
  endtask

  task automatic test_go_low();
    cexp = cexp + 7'd1;
    push_frame(SX, SY, 1'b0, cexp);
    pulse_tick();
    repeat (5) @(negedge clock);
    bus_small.go = 1'b0;
    wait_done("go_low_frame", 200);
    repeat (3) @(negedge clock);
    pulse_tick();
    repeat (5) @(negedge clock);
    check_sb_empty("go_low_sb");
    check_c7("go_low_kept", cexp);
    vectors++;
    if (bus_small.busy !== 1'b0 || bus_small.bg_counter !== {1'b0, 7'(SY), 8'(SX)}) begin
      miscompares++;
      $display("FAIL idle_hold busy=%b bg_counter=%h required 0 %h", bus_small.busy,
               bus_small.bg_counter, {1'b0, 7'(SY), 8'(SX)});
    end
    push_frame(SX, SY, 1'b0, cexp);
    bus_small.go = 1'b1;
    wait_done("restart", 200);
    check_c7("restart", cexp);
    bus_small.go = 1'b0;
    repeat (PD + 3) @(negedge clock);
    check_sb_empty("restart_sb");
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    use_small = 1'b0; sb_en = 1'b0;
    n_ld = 0; n_plot = 0; n_fd = 0;
    hist = '0; cexp = '0;
    bus_full.go = 1'b0;  bus_full.frame_tick = 1'b0;  bus_full.pause = 1'b0;
    bus_small.go = 1'b0; bus_small.frame_tick = 1'b0; bus_small.pause = 1'b0;
    resetn = 1'b1;
    #2 resetn = 1'b0;
    test_reset();
    test_full_frame();
    test_first_and_step();
    test_wrap();
    test_tick_dropped();
    test_pause();
    test_go_low();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog time=%0t required finish earlier", $time);
    $fatal(1, "watchdog");
  end
endmodule
